alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Multi-cycle control FSM for the 8-bit processor core. Fetches instruction bytes over a
//  req/valid port, decodes them, drives alu opcode/register-file controls for exactly one
//  cycle per op, waits out the ALU's registered result and flag latency, then updates PC.
//  Sits between program memory and the alu/reg_file datapath; sole driver of alu_instruction_code.
// PARAMETERS
//  PC_W      8   program counter / jump target width (bits)
//  RF_AW     4   register-file address width (instr[3:0])
//  RESET_PC  0   PC value loaded on reset
// PORTS
//  clk            in   1      core clock; all state updates on posedge
//  rst_n          in   1      asynchronous, active-low reset
//  imem_req       out  1      fetch request; held until imem_valid
//  imem_addr      out  PC_W   fetch address (= pc)
//  imem_data      in   8      fetched byte, sampled when imem_valid=1
//  imem_valid     in   1      imem_data valid this cycle (any latency >=0 cycles after req)
//  alu_op         out  4      to alu instruction-code input; `NOP when not executing
//  rf_addr        out  RF_AW  register-file address (instr[3:0]), held from DECODE to next FETCH
//  rf_we          out  1      1-cycle write of accumulator into rf[rf_addr] (ST)
//  acu_load       out  1      1-cycle load of accumulator from rf[rf_addr] (LD)
//  flag_z_in      in   1      alu zero flag
//  flag_cy_in     in   1      alu carry flag
//  z_q, cy_q      out  1      architectural Z/CY latched by the sequencer
//  pc             out  PC_W   current program counter
//  halted         out  1      1 while in HALT
// BEHAVIOUR
//  Reset (async, rst_n=0): state=FETCH, pc=RESET_PC, alu_op=`NOP, imem_req=0, rf_we=0,
//   acu_load=0, z_q=0, cy_q=0, halted=0, rf_addr=0, instr=0. imem_req asserts 1st cycle after release.
//  Encoding: instr[7:4]=opcode, instr[3:0]=reg. ALU opcodes (NOT..INC) as in instructions.v;
//   remaining six codes LD, ST, JMP, JZ, NOP, HALT added there. JMP/JZ take a 2nd byte = target.
//  States: FETCH, DECODE, OPERAND, EXEC, SETTLE, FLAGS, HALT.
//  FETCH: imem_req=1 until imem_valid; on valid latch instr, pc<=pc+1 (mod 2^PC_W), ->DECODE.
//  DECODE (1 cyc): ALU op->EXEC; LD->acu_load=1, ->FETCH; ST->rf_we=1, ->FETCH;
//   JMP/JZ->OPERAND; NOP->FETCH; HALT->HALT.
//  OPERAND: imem_req=1 until valid; pc<=target if JMP, or JZ with z_q=1; else pc<=pc+1. ->FETCH.
//  EXEC (1 cyc): alu_op=opcode exactly this cycle (alu is ungated; any other cycle drives `NOP).
//  SETTLE (1 cyc): accumulator updated at end of EXEC; alu flag regs update at end of SETTLE.
//  FLAGS (1 cyc): z_q<=flag_z_in; cy_q<=flag_cy_in only if opcode was ADD; ->FETCH.
//  ALU op latency: FETCH(>=1)+DECODE+EXEC+SETTLE+FLAGS = 5 cycles min with 0-wait memory.
//  HALT: absorbing; imem_req=0, alu_op=`NOP; exits only by reset.
//  Outputs registered; at most one of rf_we/acu_load/(alu_op!=`NOP) high in any cycle.
//  imem_valid while imem_req=0 ignored. PC wrap: 2^PC_W-1 +1 -> 0, no flag.
//  Reset mid-instruction: discards instr and pending fetch; memory must drop late valid.
//  Undefined opcodes: none (all 16 decoded).
// STRUCTURE
//  instructions.v: all 16 opcode defines plus state encodings (SEQ_FETCH..SEQ_HALT).
//  Single module; no sub-module. PC incrementer and decode inline.
// TESTING
//  0-wait mem, ADD r1 with acu=0xF0, r1=0x20 -> alu_op=`ADD exactly 1 cyc; cy_q=1, z_q=0 by FLAGS.
//  imem_valid delayed 3 cyc -> imem_req held, pc stable, no alu_op/rf_we pulses during wait.
//  SUB giving 0, then JZ 0x40 -> z_q=1, pc=0x40; repeat with nonzero -> pc = JZ addr+2.
//  pc=0xFF, NOP fetched -> pc wraps to 0x00, next imem_addr=0x00.
//  rst_n low during SETTLE -> immediate pc=RESET_PC, alu_op=`NOP, z_q=cy_q=0; clean fetch after release.
//  HALT then 20 cycles imem_valid toggling -> halted=1, pc frozen, imem_req=0, alu_op=`NOP throughout.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared opcode and state encodings for the 8-bit core's instruction sequencer.
// High nibble of an instruction byte is the opcode; low nibble selects a register.
package alu_sequencer_pkg;

    typedef enum logic [3:0] {
        OP_NOT  = 4'h0,
        OP_AND  = 4'h1,
        OP_OR   = 4'h2,
        OP_XOR  = 4'h3,
        OP_ADD  = 4'h4,
        OP_SUB  = 4'h5,
        OP_SHL  = 4'h6,
        OP_SHR  = 4'h7,
        OP_DEC  = 4'h8,
        OP_INC  = 4'h9,
        OP_LD   = 4'hA,
        OP_ST   = 4'hB,
        OP_JMP  = 4'hC,
        OP_JZ   = 4'hD,
        OP_NOP  = 4'hE,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        SEQ_FETCH   = 3'd0,
        SEQ_DECODE  = 3'd1,
        SEQ_OPERAND = 3'd2,
        SEQ_EXEC    = 3'd3,
        SEQ_SETTLE  = 3'd4,
        SEQ_FLAGS   = 3'd5,
        SEQ_HALT    = 3'd6
    } seq_state_e;

    localparam logic [3:0] NOP_CODE = 4'hE;

    // ALU opcodes occupy the contiguous low range NOT..INC.
    function automatic logic is_alu_op(input opcode_e op);
        return (op <= OP_INC);
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/decode/execute control FSM for the 8-bit core.
// All outputs are registered; the ALU sees a non-NOP opcode for exactly one cycle per op.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter int              RF_AW    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [7:0]       imem_data,
    input  logic             imem_valid,
    output logic [3:0]       alu_op,
    output logic [RF_AW-1:0] rf_addr,
    output logic             rf_we,
    output logic             acu_load,
    input  logic             flag_z_in,
    input  logic             flag_cy_in,
    output logic             z_q,
    output logic             cy_q,
    output logic [PC_W-1:0]  pc,
    output logic             halted
);

    seq_state_e       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    opcode_e          op_q, op_d;
    logic [RF_AW-1:0] rf_addr_q, rf_addr_d;
    logic             imem_req_q, imem_req_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic             rf_we_q, rf_we_d;
    logic             acu_load_q, acu_load_d;
    logic             z_d, cy_d;
    logic             halted_q, halted_d;

    opcode_e          fetched_op;
    logic             handshake;
    logic [PC_W-1:0]  pc_inc;

    // A valid byte only counts while we are actually requesting one.
    assign handshake  = imem_req_q & imem_valid;
    assign fetched_op = opcode_e'(imem_data[7:4]);
    assign pc_inc     = pc_q + PC_W'(1);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        op_d      = op_q;
        rf_addr_d = rf_addr_q;
        z_d       = z_q;
        cy_d      = cy_q;

        case (state_q)
            SEQ_FETCH: begin
                if (handshake) begin
                    op_d      = fetched_op;
                    rf_addr_d = imem_data[RF_AW-1:0];
                    pc_d      = pc_inc;
                    state_d   = SEQ_DECODE;
                end
            end
            SEQ_DECODE: begin
                if (is_alu_op(op_q)) begin
                    state_d = SEQ_EXEC;
                end else begin
                    case (op_q)
                        OP_JMP, OP_JZ: state_d = SEQ_OPERAND;
                        OP_HALT:       state_d = SEQ_HALT;
                        default:       state_d = SEQ_FETCH;
                    endcase
                end
            end
            SEQ_OPERAND: begin
                // Only JMP and JZ reach this state, so z_q alone decides a JZ.
                if (handshake) begin
                    if (op_q == OP_JMP || z_q) begin
                        pc_d = PC_W'(imem_data);
                    end else begin
                        pc_d = pc_inc;
                    end
                    state_d = SEQ_FETCH;
                end
            end
            SEQ_EXEC: begin
                state_d = SEQ_SETTLE;
            end
            SEQ_SETTLE: begin
                state_d = SEQ_FLAGS;
            end
            SEQ_FLAGS: begin
                z_d = flag_z_in;
                if (op_q == OP_ADD) begin
                    cy_d = flag_cy_in;
                end
                state_d = SEQ_FETCH;
            end
            SEQ_HALT: begin
                state_d = SEQ_HALT;
            end
            default: begin
                state_d = SEQ_FETCH;
            end
        endcase
    end

    // Outputs are computed from the next state so they line up with it after the edge.
    always_comb begin
        imem_req_d = (state_d == SEQ_FETCH) || (state_d == SEQ_OPERAND);
        alu_op_d   = (state_d == SEQ_EXEC) ? op_q : NOP_CODE;
        rf_we_d    = (state_q == SEQ_FETCH) && handshake && (fetched_op == OP_ST);
        acu_load_d = (state_q == SEQ_FETCH) && handshake && (fetched_op == OP_LD);
        halted_d   = (state_d == SEQ_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SEQ_FETCH;
            pc_q       <= RESET_PC;
            op_q       <= OP_NOT;
            rf_addr_q  <= '0;
            imem_req_q <= 1'b0;
            alu_op_q   <= NOP_CODE;
            rf_we_q    <= 1'b0;
            acu_load_q <= 1'b0;
            z_q        <= 1'b0;
            cy_q       <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            op_q       <= op_d;
            rf_addr_q  <= rf_addr_d;
            imem_req_q <= imem_req_d;
            alu_op_q   <= alu_op_d;
            rf_we_q    <= rf_we_d;
            acu_load_q <= acu_load_d;
            z_q        <= z_d;
            cy_q       <= cy_d;
            halted_q   <= halted_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign alu_op    = alu_op_q;
    assign rf_addr   = rf_addr_q;
    assign rf_we     = rf_we_q;
    assign acu_load  = acu_load_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: an ISA-level reference run of each program predicts
// the fetch/ALU/LD/ST event stream, and a monitor compares it with what the DUT emits.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic [7:0] imem_data;
    logic       imem_valid;
    logic [3:0] alu_op;
    logic [3:0] rf_addr;
    logic       rf_we;
    logic       acu_load;
    logic       flag_z_in;
    logic       flag_cy_in;
    logic       z_q;
    logic       cy_q;
    logic [7:0] pc;
    logic       halted;

    always #5 clk = ~clk;

    alu_sequencer #(.PC_W(8), .RF_AW(4), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data), .imem_valid(imem_valid),
        .alu_op(alu_op), .rf_addr(rf_addr), .rf_we(rf_we), .acu_load(acu_load),
        .flag_z_in(flag_z_in), .flag_cy_in(flag_cy_in),
        .z_q(z_q), .cy_q(cy_q), .pc(pc), .halted(halted)
    );

    typedef enum int {EV_FETCH, EV_ALU, EV_LD, EV_ST} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       val;
        bit       z;
        bit       cy;
    } ev_t;

    ev_t        exp_q[$];
    int         checks = 0;
    int         errors = 0;

    logic [7:0] mem [256];
    int         mem_lat_min = 0;
    int         mem_lat_max = 0;
    bit         mem_override = 0;
    bit         mon_en = 0;

    // Datapath model (accumulator, register file, registered ALU flags).
    logic [7:0] acc;
    logic [7:0] rf [16];
    logic [7:0] init_acc;
    logic [7:0] init_rf [16];
    int         load_seq = 0;

    int         exp_pc;
    bit         exp_z, exp_cy, exp_halt;
    logic [7:0] exp_acc;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic void alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                   output logic [7:0] r, output logic c);
        logic [8:0] w;
        c = 1'b0;
        case (op)
            4'h0: r = ~a;
            4'h1: r = a & b;
            4'h2: r = a | b;
            4'h3: r = a ^ b;
            4'h4: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8]; end
            4'h5: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8]; end
            4'h6: begin r = {a[6:0], 1'b0}; c = a[7]; end
            4'h7: begin r = {1'b0, a[7:1]}; c = a[0]; end
            4'h8: r = a - 8'd1;
            4'h9: r = a + 8'd1;
            default: r = a;
        endcase
    endfunction

    task automatic push_ev(input ev_kind_e k, input int v, input bit z, input bit cy);
        ev_t e;
        e.kind = k; e.val = v; e.z = z; e.cy = cy;
        exp_q.push_back(e);
    endtask

    // Instruction-level interpretation of the program in mem.
    task automatic ref_run();
        int         p;
        bit         z, cy;
        logic [7:0] a, ins, res;
        logic [7:0] m [16];
        logic [3:0] op, ri;
        logic       c;
        p = 0; z = 0; cy = 0; a = init_acc; exp_halt = 0;
        for (int i = 0; i < 16; i++) m[i] = init_rf[i];
        for (int steps = 0; steps < 400 && !exp_halt; steps++) begin
            push_ev(EV_FETCH, p, z, cy);
            ins = mem[p];
            op = ins[7:4];
            ri = ins[3:0];
            p = (p + 1) % 256;
            if (op <= 4'h9) begin
                push_ev(EV_ALU, int'(op), z, cy);
                alu_fn(op, a, m[ri], res, c);
                a = res;
                z = (res == 8'h00);
                if (op == OP_ADD) cy = c;
            end else if (op == OP_LD) begin
                push_ev(EV_LD, int'(ri), z, cy);
                a = m[ri];
            end else if (op == OP_ST) begin
                push_ev(EV_ST, int'(ri), z, cy);
                m[ri] = a;
            end else if (op == OP_JMP || op == OP_JZ) begin
                push_ev(EV_FETCH, p, z, cy);
                if (op == OP_JMP || z) p = int'(mem[p]);
                else p = (p + 1) % 256;
            end else if (op == OP_HALT) begin
                exp_halt = 1;
            end
        end
        exp_pc = p; exp_z = z; exp_cy = cy; exp_acc = a;
    endtask

    // Program memory with configurable wait states; drops everything while in reset.
    initial begin
        int lat_cnt;
        int cur_lat;
        imem_valid = 1'b0; imem_data = 8'h00; lat_cnt = 0; cur_lat = 0;
        forever begin
            @(posedge clk); #1;
            if (mem_override) begin
                imem_valid = ~imem_valid;
                imem_data  = 8'($urandom);
            end else begin
                imem_valid = 1'b0;
                if (!rst_n) begin
                    lat_cnt = 0;
                    cur_lat = int'($urandom_range(mem_lat_max, mem_lat_min));
                end else if (imem_req) begin
                    if (lat_cnt >= cur_lat) begin
                        imem_valid = 1'b1;
                        imem_data  = mem[imem_addr];
                        lat_cnt    = 0;
                        cur_lat    = int'($urandom_range(mem_lat_max, mem_lat_min));
                    end else begin
                        lat_cnt++;
                    end
                end
            end
        end
    end

    // Accumulator/register-file/ALU environment reacting to the sequencer's control pulses.
    initial begin
        logic [3:0] s_op, s_addr;
        logic       s_we, s_ld, s_rst, c, pz, pcy;
        logic [7:0] res;
        bit         pend;
        int         seen;
        flag_z_in = 1'b0; flag_cy_in = 1'b0; acc = 8'h00; pend = 0; seen = 0; pz = 0; pcy = 0;
        for (int i = 0; i < 16; i++) rf[i] = 8'h00;
        forever begin
            @(negedge clk);
            s_op = alu_op; s_we = rf_we; s_ld = acu_load; s_addr = rf_addr; s_rst = rst_n;
            @(posedge clk); #1;
            if (load_seq != seen) begin
                acc = init_acc;
                for (int i = 0; i < 16; i++) rf[i] = init_rf[i];
                seen = load_seq;
            end
            if (pend) begin
                flag_z_in = pz; flag_cy_in = pcy; pend = 0;
            end
            if (s_rst) begin
                if (s_op != NOP_CODE) begin
                    alu_fn(s_op, acc, rf[s_addr], res, c);
                    acc = res; pz = (res == 8'h00); pcy = c; pend = 1;
                end else if (s_ld) begin
                    acc = rf[s_addr];
                end else if (s_we) begin
                    rf[s_addr] = acc;
                end
            end
        end
    end

    // Monitor: pops one expected event per observed DUT event.
    initial begin
        bit         prev_wait;
        logic [7:0] prev_addr;
        int         n_ev;
        ev_kind_e   obs_kind;
        int         obs_val;
        ev_t        e;
        prev_wait = 0; prev_addr = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n && mon_en) begin
                n_ev = int'(imem_req && imem_valid) + int'(alu_op != NOP_CODE) + int'(rf_we) + int'(acu_load);
                chk("one_pulse_per_cycle", int'(n_ev <= 1), 1);
                if (prev_wait && imem_req) chk("addr_stable_while_waiting", int'(imem_addr), int'(prev_addr));
                if (imem_req && !imem_valid) chk("no_pulse_while_waiting", n_ev, 0);
                if (n_ev == 1) begin
                    if (imem_req && imem_valid) begin obs_kind = EV_FETCH; obs_val = int'(imem_addr); end
                    else if (alu_op != NOP_CODE) begin obs_kind = EV_ALU; obs_val = int'(alu_op); end
                    else if (acu_load) begin obs_kind = EV_LD; obs_val = int'(rf_addr); end
                    else begin obs_kind = EV_ST; obs_val = int'(rf_addr); end
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_event: kind %0d val 0x%0h, expected none (t=%0t)",
                                 int'(obs_kind), obs_val, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("event_kind", int'(obs_kind), int'(e.kind));
                        chk("event_value", obs_val, e.val);
                        if (obs_kind == EV_FETCH) begin
                            chk("z_at_fetch", int'(z_q), int'(e.z));
                            chk("cy_at_fetch", int'(cy_q), int'(e.cy));
                        end
                    end
                end
                prev_wait = imem_req && !imem_valid;
                prev_addr = imem_addr;
            end else begin
                prev_wait = 0;
            end
        end
    end

    task automatic fill_halt();
        for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
    endtask

    task automatic start_prog();
        @(negedge clk);
        rst_n = 1'b0;
        mon_en = 0;
        load_seq++;
        exp_q.delete();
        ref_run();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1;
    endtask

    task automatic run_prog(input string tag, input int timeout);
        int cyc;
        start_prog();
        @(negedge clk);
        chk({tag, "_req_first_cycle"}, int'(imem_req), 1);
        cyc = 0;
        while (!halted && cyc < timeout) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_halted"}, int'(halted), 1);
        repeat (2) @(negedge clk);
        chk({tag, "_events_left"}, exp_q.size(), 0);
        chk({tag, "_pc"}, int'(pc), exp_pc);
        chk({tag, "_z"}, int'(z_q), int'(exp_z));
        chk({tag, "_cy"}, int'(cy_q), int'(exp_cy));
        chk({tag, "_acc"}, int'(acc), int'(exp_acc));
        chk({tag, "_req_idle"}, int'(imem_req), 0);
    endtask

    task automatic gen_prog(input int len);
        int         starts[$];
        int         p, s, k, t;
        logic [3:0] op;
        logic [7:0] ins;
        fill_halt();
        p = 0;
        while (p < len) begin
            op = 4'($urandom_range(0, 15));
            if (op == OP_HALT) op = 4'($urandom_range(0, 14));
            if ((op == OP_JMP || op == OP_JZ) && p + 1 >= len) op = OP_NOP;
            mem[p] = {op, 4'($urandom_range(0, 15))};
            starts.push_back(p);
            p += (op == OP_JMP || op == OP_JZ) ? 2 : 1;
        end
        // Forward-only targets on instruction boundaries guarantee the program reaches a HALT.
        for (int i = 0; i < starts.size(); i++) begin
            s = starts[i];
            ins = mem[s];
            if (ins[7:4] == OP_JMP || ins[7:4] == OP_JZ) begin
                if ($urandom_range(0, 3) == 0) begin
                    t = int'($urandom_range(128, 254));
                end else begin
                    k = int'($urandom_range(i + 1, starts.size()));
                    t = (k == starts.size()) ? p : starts[k];
                end
                mem[s + 1] = 8'(t);
            end
        end
    endtask

    initial begin
        int         cyc;
        logic [7:0] pc_frozen;
        rst_n = 1'b0;
        init_acc = 8'h00;
        for (int i = 0; i < 16; i++) init_rf[i] = 8'h00;
        fill_halt();
        repeat (3) @(negedge clk);

        chk("reset_pc", int'(pc), 0);
        chk("reset_imem_req", int'(imem_req), 0);
        chk("reset_alu_op", int'(alu_op), int'(NOP_CODE));
        chk("reset_rf_we", int'(rf_we), 0);
        chk("reset_acu_load", int'(acu_load), 0);
        chk("reset_z", int'(z_q), 0);
        chk("reset_cy", int'(cy_q), 0);
        chk("reset_halted", int'(halted), 0);
        chk("reset_rf_addr", int'(rf_addr), 0);

        // ADD r1 with acc=0xF0, r1=0x20 on zero-wait memory.
        fill_halt();
        mem[0] = 8'h41;
        init_acc = 8'hF0; init_rf[1] = 8'h20;
        run_prog("add_carry", 500);
        chk("add_carry_cy_set", int'(cy_q), 1);
        chk("add_carry_z_clear", int'(z_q), 0);

        // Once halted, toggling valid must change nothing.
        pc_frozen = pc;
        mem_override = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("halt_halted", int'(halted), 1);
            chk("halt_pc_frozen", int'(pc), int'(pc_frozen));
            chk("halt_req_low", int'(imem_req), 0);
            chk("halt_alu_nop", int'(alu_op), int'(NOP_CODE));
        end
        mem_override = 0;

        // Three-cycle memory latency with LD / ST / INC.
        mem_lat_min = 3; mem_lat_max = 3;
        fill_halt();
        mem[0] = 8'hA2; mem[1] = 8'hB3; mem[2] = 8'h90;
        init_acc = 8'h11; init_rf[2] = 8'h7F; init_rf[3] = 8'h00;
        run_prog("slow_mem", 800);
        chk("slow_mem_st_value", int'(rf[3]), 8'h7F);
        mem_lat_min = 0; mem_lat_max = 0;

        // SUB to zero then JZ 0x40 (taken), then the same with a nonzero result.
        fill_halt();
        mem[0] = 8'h52; mem[1] = 8'hD0; mem[2] = 8'h40;
        init_acc = 8'h33; init_rf[2] = 8'h33;
        run_prog("jz_taken", 500);
        chk("jz_taken_pc", int'(pc), 8'h41);
        chk("jz_taken_z", int'(z_q), 1);
        init_acc = 8'h34;
        run_prog("jz_not_taken", 500);
        chk("jz_not_taken_pc", int'(pc), 8'h04);

        // Execution runs through 0xFF and wraps to 0x00.
        fill_halt();
        mem[8'h00] = 8'hD0; mem[8'h01] = 8'h10;
        mem[8'h02] = 8'h50;
        mem[8'h03] = 8'hC0; mem[8'h04] = 8'hFF;
        mem[8'hFF] = 8'hE0;
        init_acc = 8'h05; init_rf[0] = 8'h05;
        run_prog("pc_wrap", 800);
        chk("pc_wrap_final_pc", int'(pc), 8'h11);

        // Reset asserted while the ADD sits in SETTLE.
        fill_halt();
        mem[0] = 8'h50; mem[1] = 8'h41;
        init_acc = 8'h5A; init_rf[0] = 8'h5A; init_rf[1] = 8'h90;
        start_prog();
        cyc = 0;
        while (alu_op != OP_ADD && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_reset_saw_add", int'(alu_op), int'(OP_ADD));
        chk("mid_reset_z_before", int'(z_q), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        mon_en = 0;
        #1;
        chk("mid_reset_pc", int'(pc), 0);
        chk("mid_reset_alu_op", int'(alu_op), int'(NOP_CODE));
        chk("mid_reset_z", int'(z_q), 0);
        chk("mid_reset_cy", int'(cy_q), 0);
        chk("mid_reset_req", int'(imem_req), 0);
        fill_halt();
        mem[0] = 8'h49; mem[1] = 8'hB7;
        init_acc = 8'hC0; init_rf[9] = 8'h40;
        run_prog("after_reset", 500);

        // Random programs with random wait states.
        mem_lat_min = 0; mem_lat_max = 3;
        for (int n = 0; n < 25; n++) begin
            gen_prog(30);
            init_acc = 8'($urandom);
            for (int i = 0; i < 16; i++) init_rf[i] = 8'($urandom);
            run_prog($sformatf("rand%0d", n), 3000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
